am386sx_bus_ctrl: RTL and testbench
===================================

Name: am386sx_bus_ctrl

Overview:
- Bus-slave cycle controller for the Am386SX pins on the BeMicro MAX10 headers.
- Samples ADS#, the cycle-definition pins, address and byte enables, and classifies each bus cycle.
- Forwards memory/IO cycles to a local req/ack port, drives read data back, and terminates every cycle with READY#.
- Handles interrupt-acknowledge, halt/shutdown and reserved cycles internally; flags a bus error on local timeout.

Parameters:
TIMEOUT, 255, SYS_CLK cycles in REQ with no loc_ack before the cycle is forcibly terminated (1..2^TO_W-1)
TO_W, 8, width of the timeout counter

Ports:
SYS_CLK  in  1  system clock, 50 MHz; also the CPU CLK2 source
reset_n  in  1  asynchronous, active-low reset
ph_en  in  1  one-SYS_CLK pulse marking the end of each processor clock; all cpu_* inputs are sampled only when it is 1
cpu_ads_n  in  1  ADS#
cpu_addr  in  23  A23..A1
cpu_bhe_n  in  1  BHE#
cpu_ble_n  in  1  BLE#
cpu_mio  in  1  M/IO#
cpu_dc  in  1  D/C#
cpu_wr  in  1  W/R#
cpu_d_in  in  16  D15..D0 from the CPU
cpu_d_out  out  16  read data to the CPU
cpu_d_oe  out  1  data-bus output enable
cpu_ready_n  out  1  READY#
cpu_na_n  out  1  NA#, tied to 1 (no address pipelining)
loc_req  out  1  local request
loc_addr  out  24  {A23..A1,1'b0}
loc_be  out  2  {~BHE#,~BLE#}
loc_we  out  1  1 = write
loc_io  out  1  1 = IO space
loc_wdata  out  16  write data
loc_rdata  in  16  read data; valid when loc_ack=1
loc_ack  in  1  local completion
intr_vector  in  8  vector returned on INTA
bus_err  out  1  one-SYS_CLK pulse on timeout

Behaviour:
- Reset values: cpu_ready_n=1, cpu_d_oe=0, cpu_d_out=0, cpu_na_n=1, loc_req=0, loc_addr=0, loc_be=0, loc_we=0, loc_io=0, loc_wdata=0, bus_err=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-cycle: everything returns to reset values immediately, with no local completion required.
- FSM states: IDLE, T2, REQ, RDY.
- IDLE:
  - On ph_en & ~cpu_ads_n: latch address, byte enables, {mio,dc,wr}; go to T2.
  - loc_addr, loc_be, loc_we, loc_io update at the same edge.
- Cycle type by {mio,dc,wr}:
  - 000 = INTA
  - 001 = reserved
  - 010 = IO read
  - 011 = IO write
  - 100 = code read
  - 101 = halt/shutdown
  - 110 = memory read
  - 111 = memory write
- T2: wait for the next ph_en. On that edge:
  - Writes: capture cpu_d_in into loc_wdata.
  - Memory/IO cycles: go to REQ with loc_req=1 and clear the counter.
  - INTA: cpu_d_out={8'h00,intr_vector}, cpu_d_oe=1, go to RDY.
  - 001/101: go to RDY with no data.
- REQ:
  - loc_req stays 1 until loc_ack=1. loc_ack is ignored while loc_req=0.
  - On the ack edge: loc_req=0. For reads, cpu_d_out=loc_rdata and cpu_d_oe=1. Go to RDY with cpu_ready_n=0.
  - Otherwise the counter increments each SYS_CLK.
  - If counter==TIMEOUT-1 with no ack: loc_req=0, bus_err=1 for one SYS_CLK, read data=16'hFFFF, go to RDY.
  - An ack arriving in the same cycle as the timeout wins; no bus_err.
- RDY:
  - cpu_ready_n=0 held until the next ph_en.
  - On that edge: cpu_ready_n=1, cpu_d_oe=0, go to IDLE.
  - READY# is therefore low for exactly one processor clock.
- Every cycle has at least one wait state; ADS# is first honoured again in IDLE.
- ADS# asserted while not IDLE is ignored.
- cpu_d_oe is never 1 during a write cycle.
- The counter saturates and does not wrap.

Test Plan:
- Memory read A=0x012344 (A23..A1 input 0x0091A2), BHE#=BLE#=0, {mio,dc,wr}=110, loc_ack 3 SYS_CLK after loc_req, loc_rdata=16'hBEEF -> loc_addr=0x012344, loc_be=2'b11, loc_we=0, cpu_d_out=16'hBEEF with cpu_d_oe=1, cpu_ready_n low for exactly one ph_en period, bus_err=0.
- IO write, BHE#=1, BLE#=0, cpu_d_in=16'h00A5, {mio,dc,wr}=011 -> loc_io=1, loc_we=1, loc_be=2'b01, loc_wdata=16'h00A5, cpu_d_oe stays 0, READY# pulse after ack.
- INTA with intr_vector=8'h08 -> no loc_req, cpu_d_out=16'h0008, READY# low on the processor clock after T2. Halt (101) -> READY# with cpu_d_oe=0.
- Memory read with TIMEOUT=16 and loc_ack never asserted -> loc_req drops after 16 SYS_CLK, bus_err pulses once, cpu_d_out=16'hFFFF, READY# pulse, FSM returns to IDLE.
- Second ADS# pulse during REQ -> ignored. reset_n driven low mid-REQ -> loc_req=0 and cpu_ready_n=1 immediately. After release, a new ADS# cycle completes normally.
- ack in the same cycle as timeout -> data=loc_rdata, bus_err stays 0.

Source files
------------

// File: rtl/am386sx_bus_ctrl.sv
// Am386SX bus-slave cycle controller: decodes each CPU bus cycle, forwards memory/IO
// cycles to a local req/ack port, answers INTA/halt/reserved cycles itself and ends every cycle with READY#.
module am386sx_bus_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        SYS_CLK,
  input  logic        reset_n,
  input  logic        ph_en,
  input  logic        cpu_ads_n,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_bhe_n,
  input  logic        cpu_ble_n,
  input  logic        cpu_mio,
  input  logic        cpu_dc,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_d_in,
  output logic [15:0] cpu_d_out,
  output logic        cpu_d_oe,
  output logic        cpu_ready_n,
  output logic        cpu_na_n,
  output logic        loc_req,
  output logic [23:0] loc_addr,
  output logic [1:0]  loc_be,
  output logic        loc_we,
  output logic        loc_io,
  output logic [15:0] loc_wdata,
  input  logic [15:0] loc_rdata,
  input  logic        loc_ack,
  input  logic [7:0]  intr_vector,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T2   = 2'd1,
    REQ  = 2'd2,
    RDY  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CYC_INTA  = 3'b000,
    CYC_RSVD  = 3'b001,
    CYC_IORD  = 3'b010,
    CYC_IOWR  = 3'b011,
    CYC_CODE  = 3'b100,
    CYC_HALT  = 3'b101,
    CYC_MEMRD = 3'b110,
    CYC_MEMWR = 3'b111
  } cyc_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

  state_t      state_q;
  cyc_t        cyc_q;
  logic [TO_W-1:0] cnt_q;
  logic [15:0] d_out_q;
  logic        d_oe_q;
  logic        ready_n_q;
  logic        loc_req_q;
  logic [23:0] loc_addr_q;
  logic [1:0]  loc_be_q;
  logic        loc_we_q;
  logic        loc_io_q;
  logic [15:0] loc_wdata_q;
  logic        bus_err_q;

  // Cycles that must be served by the local side; INTA, halt and reserved are answered here.
  function automatic logic is_local(input cyc_t c);
    case (c)
      CYC_IORD, CYC_IOWR, CYC_CODE, CYC_MEMRD, CYC_MEMWR: is_local = 1'b1;
      default:                                            is_local = 1'b0;
    endcase
  endfunction

  function automatic logic is_data_write(input cyc_t c);
    is_data_write = (c == CYC_IOWR) || (c == CYC_MEMWR);
  endfunction

  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cyc_q       <= CYC_INTA;
      cnt_q       <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      ready_n_q   <= 1'b1;
      loc_req_q   <= 1'b0;
      loc_addr_q  <= '0;
      loc_be_q    <= '0;
      loc_we_q    <= 1'b0;
      loc_io_q    <= 1'b0;
      loc_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ph_en && !cpu_ads_n) begin
            loc_addr_q <= {cpu_addr, 1'b0};
            loc_be_q   <= {~cpu_bhe_n, ~cpu_ble_n};
            loc_we_q   <= cpu_wr;
            loc_io_q   <= ~cpu_mio;
            cyc_q      <= cyc_t'({cpu_mio, cpu_dc, cpu_wr});
            state_q    <= T2;
          end
        end
        T2: begin
          if (ph_en) begin
            if (is_data_write(cyc_q)) begin
              loc_wdata_q <= cpu_d_in;
            end
            if (is_local(cyc_q)) begin
              loc_req_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= REQ;
            end else begin
              if (cyc_q == CYC_INTA) begin
                d_out_q <= {8'h00, intr_vector};
                d_oe_q  <= 1'b1;
              end
              ready_n_q <= 1'b0;
              state_q   <= RDY;
            end
          end
        end
        REQ: begin
          // A completion on the timeout edge takes priority over the forced termination.
          if (loc_ack) begin
            loc_req_q <= 1'b0;
            if (!is_data_write(cyc_q)) begin
              d_out_q <= loc_rdata;
              d_oe_q  <= 1'b1;
            end
            ready_n_q <= 1'b0;
            state_q   <= RDY;
          end else if (cnt_q == TO_LAST) begin
            loc_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!is_data_write(cyc_q)) begin
              d_out_q <= 16'hFFFF;
              d_oe_q  <= 1'b1;
            end
            ready_n_q <= 1'b0;
            state_q   <= RDY;
          end else if (cnt_q != TO_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RDY: begin
          if (ph_en) begin
            ready_n_q <= 1'b1;
            d_oe_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_d_out   = d_out_q;
  assign cpu_d_oe    = d_oe_q;
  assign cpu_ready_n = ready_n_q;
  assign cpu_na_n    = 1'b1;
  assign loc_req     = loc_req_q;
  assign loc_addr    = loc_addr_q;
  assign loc_be      = loc_be_q;
  assign loc_we      = loc_we_q;
  assign loc_io      = loc_io_q;
  assign loc_wdata   = loc_wdata_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_am386sx_bus_ctrl.sv
// Bench for am386sx_bus_ctrl: directed bus cycles with literal expectations plus
// randomized traffic compared every clock against a transaction-level reference model.
`timescale 1ns/1ps
module tb_am386sx_bus_ctrl;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 8;
  // Per cycle type {mio,dc,wr}: served locally / carries write data.
  localparam logic [7:0] LOCAL_TAB = 8'b1101_1100;
  localparam logic [7:0] WR_TAB    = 8'b1000_1000;

  logic        SYS_CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        ph_en = 1'b0;
  logic        cpu_ads_n = 1'b1;
  logic [22:0] cpu_addr = '0;
  logic        cpu_bhe_n = 1'b1;
  logic        cpu_ble_n = 1'b1;
  logic        cpu_mio = 1'b0;
  logic        cpu_dc = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_d_in = '0;
  logic [15:0] loc_rdata = '0;
  logic        loc_ack = 1'b0;
  logic [7:0]  intr_vector = '0;
  logic [15:0] cpu_d_out;
  logic        cpu_d_oe, cpu_ready_n, cpu_na_n, loc_req, loc_we, loc_io, bus_err;
  logic [23:0] loc_addr;
  logic [1:0]  loc_be;
  logic [15:0] loc_wdata;

  am386sx_bus_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .SYS_CLK(SYS_CLK), .reset_n(reset_n), .ph_en(ph_en), .cpu_ads_n(cpu_ads_n),
    .cpu_addr(cpu_addr), .cpu_bhe_n(cpu_bhe_n), .cpu_ble_n(cpu_ble_n),
    .cpu_mio(cpu_mio), .cpu_dc(cpu_dc), .cpu_wr(cpu_wr), .cpu_d_in(cpu_d_in),
    .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe), .cpu_ready_n(cpu_ready_n),
    .cpu_na_n(cpu_na_n), .loc_req(loc_req), .loc_addr(loc_addr), .loc_be(loc_be),
    .loc_we(loc_we), .loc_io(loc_io), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .loc_ack(loc_ack), .intr_vector(intr_vector), .bus_err(bus_err)
  );

  initial forever #10 SYS_CLK = ~SYS_CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction and where it is in its life.
  bit          m_wait, m_local, m_term;
  logic [2:0]  m_kind;
  int          m_age;
  logic        e_req, e_rdy_n, e_oe, e_err, e_we, e_io;
  logic [23:0] e_addr;
  logic [1:0]  e_be;
  logic [15:0] e_wdata, e_dout;

  task automatic model_reset();
    m_wait = 0; m_local = 0; m_term = 0; m_kind = '0; m_age = 0;
    e_req = 0; e_rdy_n = 1; e_oe = 0; e_err = 0; e_we = 0; e_io = 0;
    e_addr = '0; e_be = '0; e_wdata = '0; e_dout = '0;
  endtask

  task automatic finish_local(input logic [15:0] data, input logic err);
    m_local = 0;
    e_req   = 0;
    e_err   = err;
    if (!m_kind[0]) begin
      e_dout = data;
      e_oe   = 1;
    end
    e_rdy_n = 0;
    m_term  = 1;
  endtask

  task automatic model_step();
    e_err = 0;
    if (m_term) begin
      if (ph_en) begin
        m_term = 0; e_rdy_n = 1; e_oe = 0;
      end
    end else if (m_local) begin
      m_age++;
      if (loc_ack) finish_local(loc_rdata, 1'b0);
      else if (m_age >= TIMEOUT) finish_local(16'hFFFF, 1'b1);
    end else if (m_wait) begin
      if (ph_en) begin
        m_wait = 0;
        if (WR_TAB[m_kind]) e_wdata = cpu_d_in;
        if (LOCAL_TAB[m_kind]) begin
          m_local = 1; e_req = 1; m_age = 0;
        end else begin
          if (m_kind == 3'b000) begin
            e_dout = {8'h00, intr_vector};
            e_oe   = 1;
          end
          e_rdy_n = 0;
          m_term  = 1;
        end
      end
    end else if (ph_en && !cpu_ads_n) begin
      m_kind = {cpu_mio, cpu_dc, cpu_wr};
      e_addr = {cpu_addr, 1'b0};
      e_be   = {~cpu_bhe_n, ~cpu_ble_n};
      e_we   = cpu_wr;
      e_io   = ~cpu_mio;
      m_wait = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge SYS_CLK or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge SYS_CLK);
    #1;
    chk("ctl{rdy_n,req,oe,err,na}", 32'({cpu_ready_n, loc_req, cpu_d_oe, bus_err, cpu_na_n}),
        32'({e_rdy_n, e_req, e_oe, e_err, 1'b1}));
    chk("addr{addr,be,we,io}", 32'({loc_addr, loc_be, loc_we, loc_io}),
        32'({e_addr, e_be, e_we, e_io}));
    chk("wdata", 32'(loc_wdata), 32'(e_wdata));
    chk("dout", 32'(cpu_d_out), 32'(e_dout));
    chk("oe_during_write", 32'(cpu_d_oe & loc_we), 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge SYS_CLK);
    ph_en = ~ph_en;
  endtask

  task automatic align_ph();
    do tick(); while (!ph_en);
  endtask

  task automatic start_cycle(input logic [22:0] a, input logic bhe, input logic ble, input logic [2:0] k);
    align_ph();
    cpu_addr = a; cpu_bhe_n = bhe; cpu_ble_n = ble;
    {cpu_mio, cpu_dc, cpu_wr} = k;
    cpu_ads_n = 0;
    tick();
    cpu_ads_n = 1;
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    while (!loc_req && n < bound) begin
      tick();
      n++;
    end
    chk("wait_loc_req", 32'(loc_req), 1);
  endtask

  int lowph, hicnt, errcnt;

  initial begin
    reset_n = 0;
    repeat (3) tick();
    chk("rst_ready_n", 32'(cpu_ready_n), 1);
    chk("rst_oe", 32'(cpu_d_oe), 0);
    chk("rst_dout", 32'(cpu_d_out), 0);
    chk("rst_req", 32'(loc_req), 0);
    chk("rst_addr", 32'({loc_addr, loc_be, loc_we, loc_io}), 0);
    chk("rst_err_na", 32'({bus_err, cpu_na_n}), 1);
    reset_n = 1;
    repeat (2) tick();

    // Memory read, ack three clocks after request.
    start_cycle(23'h0091A2, 1'b0, 1'b0, 3'b110);
    wait_req(4);
    chk("mr_addr", 32'(loc_addr), 'h012344);
    chk("mr_be_we_io", 32'({loc_be, loc_we, loc_io}), 'b1100);
    tick(); tick();
    loc_ack = 1; loc_rdata = 16'hBEEF;
    tick();
    loc_ack = 0; loc_rdata = 16'h0000;
    chk("mr_ready_n", 32'(cpu_ready_n), 0);
    chk("mr_dout", 32'(cpu_d_out), 'hBEEF);
    chk("mr_oe_req_err", 32'({cpu_d_oe, loc_req, bus_err}), 'b100);
    lowph = 0;
    repeat (4) begin
      if (!cpu_ready_n && ph_en) lowph++;
      tick();
    end
    chk("mr_ready_ph_periods", lowph, 1);
    chk("mr_end", 32'({cpu_ready_n, cpu_d_oe}), 'b10);

    // IO write, low byte only.
    cpu_d_in = 16'h00A5;
    start_cycle(23'h000040, 1'b1, 1'b0, 3'b011);
    wait_req(4);
    chk("iow_io_we_be", 32'({loc_io, loc_we, loc_be}), 'b1101);
    chk("iow_wdata", 32'(loc_wdata), 'h00A5);
    tick();
    loc_ack = 1;
    tick();
    loc_ack = 0;
    chk("iow_ready_oe", 32'({cpu_ready_n, cpu_d_oe}), 'b00);
    repeat (4) tick();
    chk("iow_end", 32'(cpu_ready_n), 1);

    // INTA answered locally.
    intr_vector = 8'h08;
    start_cycle(23'h000000, 1'b0, 1'b0, 3'b000);
    tick(); tick();
    chk("inta_ready_req", 32'({cpu_ready_n, loc_req}), 'b00);
    chk("inta_dout_oe", 32'({cpu_d_out, cpu_d_oe}), 'h00011);
    repeat (4) tick();

    // Halt: READY# without data.
    start_cycle(23'h000001, 1'b0, 1'b1, 3'b101);
    tick(); tick();
    chk("halt_ready_oe_req", 32'({cpu_ready_n, cpu_d_oe, loc_req}), 'b000);
    repeat (4) tick();

    // Timeout with no ack.
    start_cycle(23'h001234, 1'b0, 1'b0, 3'b110);
    wait_req(4);
    hicnt = 0; errcnt = 0;
    repeat (24) begin
      if (loc_req) hicnt++;
      if (bus_err) errcnt++;
      tick();
    end
    chk("to_req_clocks", hicnt, 16);
    chk("to_bus_err_pulses", errcnt, 1);
    chk("to_dout", 32'(cpu_d_out), 'hFFFF);
    chk("to_idle", 32'({cpu_ready_n, loc_req, cpu_d_oe}), 'b100);

    // Ack on the very edge the timeout would fire.
    start_cycle(23'h002000, 1'b0, 1'b0, 3'b110);
    wait_req(4);
    repeat (15) tick();
    chk("tie_req_open", 32'(loc_req), 1);
    loc_ack = 1; loc_rdata = 16'h5A5A;
    tick();
    loc_ack = 0;
    chk("tie_dout", 32'(cpu_d_out), 'h5A5A);
    chk("tie_err_ready_req", 32'({bus_err, cpu_ready_n, loc_req}), 'b000);
    repeat (4) tick();

    // ADS# during REQ is ignored, then reset mid-REQ.
    start_cycle(23'h0091A2, 1'b0, 1'b0, 3'b110);
    wait_req(4);
    align_ph();
    cpu_addr = 23'h7FFFFF; {cpu_mio, cpu_dc, cpu_wr} = 3'b011; cpu_ads_n = 0;
    tick();
    cpu_ads_n = 1;
    tick(); tick();
    chk("ads_ign_addr", 32'(loc_addr), 'h012344);
    chk("ads_ign_req_rdy", 32'({loc_req, cpu_ready_n, loc_we}), 'b110);
    #3 reset_n = 0;
    #1;
    chk("midrst_req_rdy_oe", 32'({loc_req, cpu_ready_n, cpu_d_oe}), 'b010);
    tick(); tick();
    reset_n = 1;
    tick();

    // Fresh memory write after reset.
    cpu_d_in = 16'h1234;
    start_cycle(23'h000100, 1'b0, 1'b0, 3'b111);
    wait_req(4);
    chk("post_addr", 32'(loc_addr), 'h000200);
    chk("post_wdata_we", 32'({loc_wdata, loc_we}), 'h2469);
    tick();
    loc_ack = 1;
    tick();
    loc_ack = 0;
    chk("post_ready", 32'(cpu_ready_n), 0);
    repeat (4) tick();
    chk("post_end", 32'(cpu_ready_n), 1);

    // Randomized traffic: frequent acks, then sparse acks to provoke timeouts.
    for (int seg = 0; seg < 2; seg++) begin
      int ackdiv;
      ackdiv = (seg == 0) ? 5 : 40;
      repeat (2500) begin
        tick();
        cpu_ads_n   = ($urandom_range(0, 3) != 0);
        cpu_addr    = 23'($urandom);
        cpu_bhe_n   = 1'($urandom);
        cpu_ble_n   = 1'($urandom);
        {cpu_mio, cpu_dc, cpu_wr} = 3'($urandom);
        cpu_d_in    = 16'($urandom);
        loc_rdata   = 16'($urandom);
        intr_vector = 8'($urandom);
        loc_ack     = ($urandom_range(0, ackdiv - 1) == 0);
      end
    end
    cpu_ads_n = 1; loc_ack = 0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
